// File: rtl/y_sram_fetch.sv
// Y-matrix SRAM fetch engine: accepts one or two row addresses, issues pipelined SRAM reads and
// returns both words on a valid/ready channel. Optional macro: YF_SAME_ADDR_BYPASS_EN.
module y_sram_fetch #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 256,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 2048
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic              req_dual,
  output logic              sram_ce,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  state_t state, state_next;

  logic [ADDR_W-1:0] addr2_q;
  logic              dual_q;
  logic              bypass_q;
  logic              oor2_q;
  logic              slot_q;

  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_rd;
  logic [RD_LAT-1:0] pipe_slot;
  logic [RD_LAT-1:0] pipe_last;

  logic accept;
  logic in1;
  logic in2;
  logic same;
  logic cap_vld;
  logic cap_rd;
  logic cap_slot;
  logic cap_last;
  logic issue_last;

  assign in1      = ({1'b0, req_addr1} < DEPTH_LIM);
  assign in2      = ({1'b0, req_addr2} < DEPTH_LIM);
  assign accept   = req_valid & req_ready;
  assign cap_vld  = pipe_vld[RD_LAT-1];
  assign cap_rd   = pipe_rd[RD_LAT-1];
  assign cap_slot = pipe_slot[RD_LAT-1];
  assign cap_last = pipe_last[RD_LAT-1];
  assign issue_last = slot_q | ~dual_q;

`ifdef YF_SAME_ADDR_BYPASS_EN
  // Identical in-range addresses share one read; the word fans out to both response slots.
  assign same = req_dual & in1 & in2 & (req_addr1 == req_addr2);
`else
  assign same = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~reset;
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        if (issue_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (cap_vld && cap_last) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr2_q   <= '0;
      dual_q    <= 1'b0;
      bypass_q  <= 1'b0;
      oor2_q    <= 1'b0;
      slot_q    <= 1'b0;
      sram_ce   <= 1'b0;
      sram_addr <= '0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
      rsp_err   <= 1'b0;
      pipe_vld  <= '0;
      pipe_rd   <= '0;
      pipe_slot <= '0;
      pipe_last <= '0;
    end else begin
      // Each issue slot is tagged so its data is captured exactly RD_LAT cycles later.
      pipe_vld[0]  <= (state == ISSUE);
      pipe_rd[0]   <= sram_ce;
      pipe_slot[0] <= slot_q;
      pipe_last[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_rd[i]   <= pipe_rd[i-1];
        pipe_slot[i] <= pipe_slot[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end

      if (accept) begin
        addr2_q   <= req_addr2;
        dual_q    <= req_dual & ~same;
        bypass_q  <= same;
        oor2_q    <= ~in2;
        slot_q    <= 1'b0;
        rsp_data1 <= '0;
        rsp_data2 <= '0;
        rsp_err   <= ~in1 | (req_dual & ~in2);
        sram_ce   <= in1;
        if (in1) sram_addr <= req_addr1;
      end else if (state == ISSUE && !slot_q && dual_q) begin
        slot_q  <= 1'b1;
        sram_ce <= ~oor2_q;
        if (!oor2_q) sram_addr <= addr2_q;
      end else begin
        sram_ce <= 1'b0;
      end

      if (cap_vld && cap_rd) begin
        if (!cap_slot) begin
          rsp_data1 <= sram_rdata;
          if (bypass_q) rsp_data2 <= sram_rdata;
        end else begin
          rsp_data2 <= sram_rdata;
        end
      end
    end
  end

endmodule
